// File: rtl/result_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : result_stream_reader                                       |
// | Description : Reads a contiguous window of rows from the result BRAM R   |
// |               and emits one valid/ready beat per row. A credit check     |
// |               covers rows still in the read pipeline, so the output      |
// |               FIFO cannot overflow under any backpressure.               |
// | Ports       : clk, rst         - clock, synchronous active-high reset    |
// |               start            - begin transfer (sampled in IDLE only)   |
// |               base_addr        - first row address, sampled with start   |
// |               row_count        - rows to transfer, sampled with start    |
// |               busy / done      - transfer status / completion pulse      |
// |               bram_r_r_addr    - registered BRAM R read address          |
// |               bram_r_r_data    - BRAM R read data (lane 0 in LSBs)       |
// |               m_tdata/m_tvalid/m_tready/m_tlast - output row stream      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module result_stream_reader #(
  parameter int PE_COUNT     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int R_ADDR_WIDTH = 11,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [R_ADDR_WIDTH-1:0]        base_addr,
  input  logic [R_ADDR_WIDTH:0]          row_count,
  output logic                           busy,
  output logic                           done,
  output logic [R_ADDR_WIDTH-1:0]        bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
  output logic [PE_COUNT*DATA_WIDTH-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast
);

  localparam int ROW_W = PE_COUNT * DATA_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [R_ADDR_WIDTH-1:0]   addr_q, addr_d;
  // addr_vld_q: the address currently on bram_r_r_addr is a fresh read.
  logic                      addr_vld_q, addr_vld_d;
  // vld_sr_q[k]: the read presented k+1 cycles ago is still travelling;
  // the top bit marks the cycle its data sits on bram_r_r_data.
  logic [READ_LATENCY-1:0]   vld_sr_q, vld_sr_d;
  logic [R_ADDR_WIDTH:0]     issue_left_q, issue_left_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          fifo_count_q, fifo_count_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [ROW_W-1:0]          mem_q [FIFO_DEPTH];

  logic                      push;
  logic                      pop;
  logic                      credit;
  logic [OCC_W-1:0]          in_flight;
  logic [OCC_W-1:0]          occupancy;

  assign push     = vld_sr_q[READ_LATENCY-1];
  assign m_tvalid = (fifo_count_q != '0);
  assign pop      = m_tvalid && m_tready;

  // Rows owned by this block: reads still travelling plus rows buffered.
  always_comb begin
    in_flight = OCC_W'(addr_vld_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + OCC_W'(vld_sr_q[i]);
    end
  end

  // A beat leaving this edge frees its slot in time for a read issued this
  // edge, which is what allows one beat per cycle at minimum FIFO depth.
  // pop implies fifo_count_q >= 1, so the subtraction cannot underflow.
  assign occupancy = in_flight + OCC_W'(fifo_count_q) - OCC_W'(pop);
  assign credit    = (occupancy < OCC_W'(FIFO_DEPTH));

  // The head is the final beat once nothing is left to issue, nothing is in
  // the pipeline and it is the only buffered row.
  assign m_tlast = m_tvalid && (state_q == S_RUN) && (issue_left_q == '0) &&
                   (in_flight == '0) && (fifo_count_q == CNT_W'(1));

  assign m_tdata       = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign bram_r_r_addr = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_vld_d   = 1'b0;
    issue_left_d = issue_left_q;

    vld_sr_d[0] = addr_vld_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_count != '0) begin
            // First read goes out on the accepting edge itself.
            state_d      = S_RUN;
            addr_d       = base_addr;
            addr_vld_d   = 1'b1;
            issue_left_d = row_count - {{R_ADDR_WIDTH{1'b0}}, 1'b1};
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if ((issue_left_q != '0) && credit) begin
          addr_d       = addr_q + R_ADDR_WIDTH'(1);
          addr_vld_d   = 1'b1;
          issue_left_d = issue_left_q - {{R_ADDR_WIDTH{1'b0}}, 1'b1};
        end
        if ((issue_left_q == '0) && (in_flight == '0) &&
            (fifo_count_q == CNT_W'(1)) && pop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    wr_ptr_d     = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d     = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CNT_W'(1);
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      addr_vld_q   <= 1'b0;
      vld_sr_q     <= '0;
      issue_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_vld_q   <= addr_vld_d;
      vld_sr_q     <= vld_sr_d;
      issue_left_q <= issue_left_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Storage is not reset: m_tdata is gated by m_tvalid, so stale rows are
  // never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bram_r_r_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_result_stream_reader                                    |
// | Description : Scoreboard bench for result_stream_reader with a BRAM R    |
// |               read-latency model and directed transfers.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_result_stream_reader;

  localparam int PE    = 4;
  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int RL    = 2;
  localparam int FD    = 4;
  localparam int ROW_W = PE * DW;
  localparam int NROWS = 1 << AW;

  typedef struct {
    logic [ROW_W-1:0] d;
    logic             l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       row_count;
  logic              busy;
  logic              done;
  logic [AW-1:0]     bram_r_r_addr;
  logic [ROW_W-1:0]  bram_r_r_data;
  logic [ROW_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  always #5 clk = ~clk;

  result_stream_reader #(
    .PE_COUNT(PE), .DATA_WIDTH(DW), .R_ADDR_WIDTH(AW),
    .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .row_count(row_count), .busy(busy), .done(done),
    .bram_r_r_addr(bram_r_r_addr), .bram_r_r_data(bram_r_r_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast)
  );

  // ---------------- BRAM R model: RL-cycle registered read ----------------
  logic [ROW_W-1:0] bram_mem [NROWS];
  logic [ROW_W-1:0] rd_pipe  [RL];

  function automatic logic [ROW_W-1:0] row_val(input int a);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < PE; k++) r[k*DW +: DW] = DW'(a * 10 + k);
    return r;
  endfunction

  initial begin
    for (int a = 0; a < NROWS; a++) bram_mem[a] = row_val(a);
  end

  always @(posedge clk) begin
    rd_pipe[0] <= bram_mem[bram_r_r_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_r_r_data = rd_pipe[RL-1];

  // ---------------- bookkeeping ----------------
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  beat_t exp_q[$];

  int    mode = 0;          // 0: ready=1, 1: 1,0,0,1 pattern, 2: ready=0, 3: ready for 3 beats
  int    beats_seen = 0;
  int    first_cyc = -1;
  int    last_hs_cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    done_base = 0;
  int    t0 = 0;
  bit    ahead_en = 0;
  int    issued = 0;
  int    acc_done = 0;
  logic [AW-1:0]    prev_addr = '0;
  bit               stall_prev = 0;
  logic [ROW_W-1:0] stall_data;
  logic             stall_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_row(input string nm, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        3:       m_tready = (beats_seen < 3);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (ahead_en) begin
        if (bram_r_r_addr != prev_addr) issued++;
        chk("addr_ahead_le_depth", int'((issued - acc_done) <= FD), 1);
      end
      prev_addr = bram_r_r_addr;
      if (stall_prev) begin
        chk("hold_valid", int'(m_tvalid), 1);
        chk_row("hold_data", m_tdata, stall_data);
        chk("hold_last", int'(m_tlast), int'(stall_last));
      end
      if (m_tvalid && first_cyc < 0) first_cyc = cyc;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %h expected no beat", m_tdata);
        end else begin
          b = exp_q.pop_front();
          chk_row("beat_data", m_tdata, b.d);
          chk("beat_last", int'(m_tlast), int'(b.l));
        end
        beats_seen++;
        last_hs_cyc = cyc;
        acc_done++;
      end
      stall_prev = m_tvalid && !m_tready;
      stall_data = m_tdata;
      stall_last = m_tlast;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_xfer(input int base, input int cnt);
    beat_t b;
    @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = AW'(base);
    row_count  = (AW+1)'(cnt);
    t0         = cyc;
    first_cyc  = -1;
    beats_seen = 0;
    done_base  = done_cnt;
    for (int i = 0; i < cnt; i++) begin
      b.d = row_val((base + i) % NROWS);
      b.l = (i == cnt - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == done_base) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", nm, budget);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a0;
    int db;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    row_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_tlast", int'(m_tlast), 0);
    chk_row("rst_tdata", m_tdata, '0);
    chk("rst_addr", int'(bram_r_r_addr), 0);
    rst = 1'b0;

    // T1: 70 rows, full throughput
    mode = 0;
    start_xfer(0, 70);
    wait_done("t1", 400);
    chk("t1_first_valid_latency", first_cyc - t0, 4);
    chk("t1_throughput", last_hs_cyc - first_cyc, 69);
    chk("t1_done_after_last", done_cyc - last_hs_cyc, 1);
    chk("t1_beats", beats_seen, 70);
    chk("t1_queue_empty", exp_q.size(), 0);

    // T2: backpressure pattern, rows 5..12
    mode     = 1;
    issued   = 0;
    acc_done = 0;
    ahead_en = 1;
    start_xfer(5, 8);
    wait_done("t2", 200);
    ahead_en = 0;
    chk("t2_beats", beats_seen, 8);
    chk("t2_issued", issued, 8);
    chk("t2_queue_empty", exp_q.size(), 0);
    mode = 0;

    // T3: address wrap 2046, 2047, 0, 1
    start_xfer(2046, 4);
    wait_done("t3", 100);
    chk("t3_beats", beats_seen, 4);
    chk("t3_queue_empty", exp_q.size(), 0);

    // T4: zero-length transfer
    a0 = int'(bram_r_r_addr);
    start_xfer(7, 0);
    @(negedge clk);
    chk("t4_done_pulse", int'(done), 1);
    chk("t4_busy_pulse", int'(busy), 1);
    chk("t4_tvalid", int'(m_tvalid), 0);
    @(negedge clk);
    chk("t4_done_low", int'(done), 0);
    chk("t4_busy_low", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("t4_addr_unchanged", int'(bram_r_r_addr), a0);
    chk("t4_no_beats", beats_seen, 0);
    chk("t4_done_count", done_cnt, done_base + 1);

    // T5: reset mid-transfer with a stalled stream
    mode = 3;
    start_xfer(0, 70);
    n = 0;
    while (beats_seen < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_three_beats", beats_seen, 3);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_stalled_valid", int'(m_tvalid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_tvalid_cleared", int'(m_tvalid), 0);
    chk("t5_busy_cleared", int'(busy), 0);
    chk("t5_done_low", int'(done), 0);
    db = done_cnt;
    repeat (10) @(negedge clk);
    chk("t5_no_done", done_cnt, db);
    mode = 0;
    start_xfer(0, 2);
    wait_done("t5b", 100);
    chk("t5b_beats", beats_seen, 2);
    chk("t5b_queue_empty", exp_q.size(), 0);

    // T6: start while busy is ignored
    start_xfer(10, 6);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(100);
    row_count = (AW+1)'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t6", 100);
    repeat (10) @(negedge clk);
    chk("t6_beats", beats_seen, 6);
    chk("t6_single_done", done_cnt, done_base + 1);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_idle_tvalid", int'(m_tvalid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
